dmx1xn_stream: RTL and testbench
================================

DMX1XN_STREAM -- requirements
Module: dmx1xn_stream

Interface
REQ-001 Parameter N, default 4: number of output channels, 2..16.
REQ-002 Parameter W, default 8: data width per beat, 1..64.
REQ-003 Parameter SW, default $clog2(N): select width (derived, not overridden).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  block enable; 0 blocks new accepts, and draining continues.
REQ-007 i_valid  input  1  input beat valid.
REQ-008 i_data  input  W  input beat data.
REQ-009 s  input  SW  destination channel select, sampled with the beat.
REQ-010 i_ready  output  1  input can accept this cycle.
REQ-011 y_valid  output  N  per-channel output valid.
REQ-012 y_data  output  N*W  channel k occupies bits [k*W +: W].
REQ-013 y_ready  input  N  per-channel downstream ready.
REQ-014 drop_cnt  output  8  saturating count of beats dropped for an out-of-range select.

Function
REQ-015 Each channel SHALL have a one-entry holding register (valid bit plus W data bits).
REQ-016 Target channel: t = s in select mode, t = rr_ptr in round-robin mode (REQ-030).
REQ-017 i_ready SHALL equal en && (t >= N || !y_valid[t] || y_ready[t]), combinationally.
REQ-018 An accept occurs when i_valid && i_ready; the beat appears on y_valid[t]/y_data[t] the next cycle, with a fixed latency of 1.
REQ-019 An accept into a channel that is draining in the same cycle SHALL replace that channel's content with no bubble.
REQ-020 A channel register clears y_valid[k] when y_valid[k] && y_ready[k] and no new accept targets k.
REQ-021 y_data[k] SHALL hold its value while y_valid[k] && !y_ready[k], and SHALL update only on an accept into k.
REQ-022 When t >= N (non-power-of-two N), the beat SHALL be accepted and discarded, and drop_cnt SHALL increment, saturating at 255.
REQ-023 While en=0, no accept occurs, but existing y_valid/y_ready handshakes SHALL complete normally.
REQ-024 Channels SHALL be independent: a stalled channel blocks only beats targeted at it.

Reset
REQ-025 While rst_n=0: y_valid=0, y_data=0, drop_cnt=0, rr_ptr=0, all asynchronously.
REQ-026 i_ready SHALL be 0 during reset regardless of en.
REQ-027 Reset asserted mid-transfer SHALL discard all held beats, and no beat SHALL be reported after deassertion.

Configuration
REQ-028 Macro DMX1XN_RR_EN selects whether round-robin mode is compiled in.
REQ-029 Without DMX1XN_RR_EN: no mode port, t = s always, and the design has no rr_ptr.
REQ-030 With DMX1XN_RR_EN: an extra input port rr_mode (1 bit) is present. When rr_mode=1, s is ignored and t = rr_ptr. rr_ptr advances 0..N-1 on each accept and wraps to 0 after N-1.
REQ-031 With DMX1XN_RR_EN, changing rr_mode SHALL NOT reset rr_ptr. rr_ptr holds its value while rr_mode=0.

Structure
REQ-032 Package dmx_pkg SHALL hold the N and W range limits, the drop_cnt width constant (8), and the channel-index helper function.
REQ-033 Sub-module dmx_chan_reg SHALL implement one channel holding register. It SHALL be instantiated N times by a generate loop.

Verification (N=4, W=8 unless stated)
REQ-034 Reset then en=1, i_valid=1, i_data=8'hA5, s=2, y_ready=4'hF -> next cycle y_valid=4'b0100, y_data[23:16]=8'hA5.
REQ-035 y_ready[1]=0, two beats 8'h11 then 8'h22 to s=1 -> first is held on channel 1, i_ready=0 on the second. Raise y_ready[1] -> 8'h22 is accepted in that same cycle, and channel 1 shows 8'h22 the next cycle.
REQ-036 en=0 with a pending i_valid for each s=0..3 -> i_ready=0 and y_valid unchanged. Repeat with en=1 and i_valid=0 -> y_valid stays 0.
REQ-037 N=5 (SW=3), s=6, 300 beats -> y_valid stays 0, and drop_cnt saturates at 255.
REQ-038 DMX1XN_RR_EN, rr_mode=1, 6 beats 8'h01..8'h06 with all ready -> the beats land on channels 0,1,2,3,0,1.
REQ-039 rst_n pulsed low while y_valid=4'b1010 and y_ready=0 -> outputs are 0 immediately, and nothing reappears after release.

Source files
------------

// File: rtl/dmx1xn_stream_pkg.sv
// dmx1xn_stream_pkg: shared limits, drop counter width and channel-index helper.
// Optional round-robin mode is enabled by defining DMX1XN_RR_EN.
package dmx_pkg;
   localparam int N_MIN  = 2;
   localparam int N_MAX  = 16;
   localparam int W_MIN  = 1;
   localparam int W_MAX  = 64;
   localparam int DROP_W = 8;
   function automatic logic in_range(input int t, input int n);
      return t < n;
   endfunction
endpackage

// File: rtl/dmx1xn_stream_if.sv
// dmx1xn_stream_if: input beat, per-channel outputs and drop counter of the 1:N demux.
interface dmx1xn_stream_if
   import dmx_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 8
);
   localparam int SW = $clog2(N);
   logic              en;
   logic              i_valid;
   logic [W-1:0]      i_data;
   logic [SW-1:0]     s;
   logic              i_ready;
   logic [N-1:0]      y_valid;
   logic [N*W-1:0]    y_data;
   logic [N-1:0]      y_ready;
   logic [DROP_W-1:0] drop_cnt;
   modport master (output en, i_valid, i_data, s, y_ready, input i_ready, y_valid, y_data, drop_cnt);
   modport slave (input en, i_valid, i_data, s, y_ready, output i_ready, y_valid, y_data, drop_cnt);
endinterface

// File: rtl/dmx1xn_stream_chan_reg.sv
// dmx_chan_reg: one-entry output holding register; a load while draining replaces the entry.
module dmx_chan_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ld,
   input  logic         rdy,
   input  logic [W-1:0] d,
   output logic         vld,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         vld <= 1'b0;
         q   <= '0;
      end else begin
         vld <= ld | (vld & ~rdy);
         if (ld) q <= d;
      end
endmodule

// File: rtl/dmx1xn_stream.sv
// dmx1xn_stream: 1:N stream demux with per-channel holding registers and drop counter.
// Define DMX1XN_RR_EN to add the rr_mode port and round-robin channel targeting.
module dmx1xn_stream
   import dmx_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 8
) (
   input logic clk,
   input logic rst_n,
`ifdef DMX1XN_RR_EN
   input logic rr_mode,
`endif
   dmx1xn_stream_if.slave bus
);
   localparam int SW = $clog2(N);
   logic [SW-1:0]     t;
   logic [N-1:0]      sel;
   logic [N-1:0]      yv;
   logic [N*W-1:0]    yd;
   logic              hit;
   logic              acc;
   logic [DROP_W-1:0] drop_cnt;
   if (N < N_MIN || N > N_MAX || W < W_MIN || W > W_MAX) begin : g_bad
      $error("dmx1xn_stream: N or W out of range");
   end
`ifdef DMX1XN_RR_EN
   logic [SW-1:0] rr_ptr;
   assign t = rr_mode ? rr_ptr : bus.s;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rr_ptr <= '0;
      else if (acc && rr_mode) rr_ptr <= (rr_ptr == SW'(N - 1)) ? '0 : rr_ptr + 1'b1;
`else
   assign t = bus.s;
`endif
   assign hit = in_range(int'(t), N);
   // an out-of-range target selects no channel, so it can never stall
   assign sel = hit ? {{(N-1){1'b0}}, 1'b1} << t : '0;
   assign bus.i_ready = rst_n && bus.en && !(|(sel & yv & ~bus.y_ready));
   assign acc = bus.i_valid && bus.i_ready;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) drop_cnt <= '0;
      else if (acc && !hit && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
   for (genvar k = 0; k < N; k++) begin : g_ch
      dmx_chan_reg #(.W(W)) u_reg (
         .clk  (clk),
         .rst_n(rst_n),
         .ld   (acc && sel[k]),
         .rdy  (bus.y_ready[k]),
         .d    (bus.i_data),
         .vld  (yv[k]),
         .q    (yd[k*W +: W])
      );
   end
   assign bus.y_valid  = yv;
   assign bus.y_data   = yd;
   assign bus.drop_cnt = drop_cnt;
endmodule

// File: tb/tb_dmx1xn_stream.sv
// tb_dmx1xn_stream: scoreboard bench for the N=4 demux plus an N=5 drop/saturation instance.
module tb_dmx1xn_stream;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
`ifdef DMX1XN_RR_EN
   logic rr_mode = 1'b0;
`endif
   int checks = 0;
   int errs = 0;
   logic [3:0] mv;
   int rp;
   logic [7:0] sq[4][$];
   dmx1xn_stream_if #(.N(4), .W(8)) b0 ();
   dmx1xn_stream_if #(.N(5), .W(8)) b1 ();
   dmx1xn_stream #(.N(4), .W(8)) u0 (
      .clk  (clk),
      .rst_n(rst_n),
`ifdef DMX1XN_RR_EN
      .rr_mode(rr_mode),
`endif
      .bus  (b0)
   );
   dmx1xn_stream #(.N(5), .W(8)) u1 (
      .clk  (clk),
      .rst_n(rst_n),
`ifdef DMX1XN_RR_EN
      .rr_mode(1'b0),
`endif
      .bus  (b1)
   );
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      checks++;
      assert (o === e) else begin
         errs++;
         $error("FAIL %s: got %0h want %0h", tag, o, e);
      end
   endtask

   // sample mid-cycle, check against the model, then advance the model across the edge
   task automatic cyc();
      int t;
      logic er;
      #4;
      t = int'(b0.s);
`ifdef DMX1XN_RR_EN
      if (rr_mode) t = rp;
`endif
      er = rst_n && b0.en && (t >= 4 || !mv[t] || b0.y_ready[t]);
      chk("i_ready", 64'(b0.i_ready), 64'(er));
      chk("y_valid", 64'(b0.y_valid), 64'(mv));
      for (int k = 0; k < 4; k++)
         if (mv[k]) chk($sformatf("y_data%0d", k), 64'(b0.y_data[k*8 +: 8]), 64'(sq[k][0]));
      for (int k = 0; k < 4; k++)
         if (mv[k] && b0.y_ready[k]) begin
            void'(sq[k].pop_front());
            mv[k] = 1'b0;
         end
      if (b0.i_valid && er) begin
         sq[t].push_back(b0.i_data);
         mv[t] = 1'b1;
`ifdef DMX1XN_RR_EN
         if (rr_mode) rp = (rp + 1) % 4;
`endif
      end
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic v, input logic [1:0] s, input logic [7:0] d);
      b0.i_valid = v;
      b0.s = s;
      b0.i_data = d;
   endtask

   initial begin
      mv = '0;
      rp = 0;
      b0.en = 1'b1; b0.i_valid = 1'b0; b0.i_data = '0; b0.s = '0; b0.y_ready = '0;
      b1.en = 1'b1; b1.i_valid = 1'b0; b1.i_data = '0; b1.s = '0; b1.y_ready = '0;
      #2;
      chk("rst_i_ready", 64'(b0.i_ready), 64'd0);
      chk("rst_y_valid", 64'(b0.y_valid), 64'd0);
      chk("rst_y_data", 64'(b0.y_data), 64'd0);
      chk("rst_drop", 64'(b1.drop_cnt), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      b0.y_ready = 4'hF;
      put(1'b1, 2'd2, 8'hA5);
      cyc();
      put(1'b0, 2'd0, 8'h00);
      chk("basic_valid", 64'(b0.y_valid), 64'b0100);
      chk("basic_data", 64'(b0.y_data[23:16]), 64'hA5);
      cyc();
      b0.y_ready = 4'b1101;
      put(1'b1, 2'd1, 8'h11);
      cyc();
      put(1'b1, 2'd1, 8'h22);
      #1 chk("stall_ready", 64'(b0.i_ready), 64'd0);
      cyc();
      cyc();
      chk("stall_hold", 64'(b0.y_data[15:8]), 64'h11);
      b0.y_ready = 4'hF;
      #1 chk("drain_ready", 64'(b0.i_ready), 64'd1);
      cyc();
      put(1'b0, 2'd0, 8'h00);
      chk("replace_valid", 64'(b0.y_valid[1]), 64'd1);
      chk("replace_data", 64'(b0.y_data[15:8]), 64'h22);
      cyc();
      b0.y_ready = 4'b0111;
      put(1'b1, 2'd3, 8'h3C);
      cyc();
      b0.en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         put(1'b1, 2'(i), 8'(8'h30 + i));
         #1 chk("en0_ready", 64'(b0.i_ready), 64'd0);
         cyc();
         chk("en0_valid", 64'(b0.y_valid), 64'b1000);
      end
      b0.y_ready = 4'hF;
      cyc();
      chk("en0_drain", 64'(b0.y_valid), 64'd0);
      b0.en = 1'b1;
      put(1'b0, 2'd0, 8'h00);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("idle_valid", 64'(b0.y_valid), 64'd0);
      end
      for (int i = 0; i < 60; i++) begin
         b0.en = ($urandom_range(0, 7) != 0);
         b0.y_ready = 4'($urandom);
         put(1'($urandom), 2'($urandom), 8'($urandom));
         cyc();
      end
      b0.en = 1'b1;
      b0.y_ready = 4'hF;
      put(1'b0, 2'd0, 8'h00);
      cyc();
      cyc();
      b0.y_ready = 4'h0;
      put(1'b1, 2'd1, 8'h5A);
      cyc();
      put(1'b1, 2'd3, 8'hC3);
      cyc();
      put(1'b0, 2'd0, 8'h00);
      cyc();
      chk("pre_rst_valid", 64'(b0.y_valid), 64'b1010);
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", 64'(b0.y_valid), 64'd0);
      chk("async_data", 64'(b0.y_data), 64'd0);
      chk("async_ready", 64'(b0.i_ready), 64'd0);
      mv = '0;
      rp = 0;
      for (int k = 0; k < 4; k++) sq[k].delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      b0.y_ready = 4'hF;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("post_rst_valid", 64'(b0.y_valid), 64'd0);
      end
`ifdef DMX1XN_RR_EN
      rr_mode = 1'b1;
      for (int i = 0; i < 6; i++) begin
         put(1'b1, 2'd3, 8'(i + 1));
         cyc();
         chk("rr_land", 64'(b0.y_valid), 64'(4'b0001 << (i % 4)));
      end
      put(1'b0, 2'd0, 8'h00);
      cyc();
      rr_mode = 1'b0;
      put(1'b1, 2'd0, 8'h77);
      cyc();
      put(1'b0, 2'd0, 8'h00);
      cyc();
      rr_mode = 1'b1;
      put(1'b1, 2'd0, 8'h88);
      cyc();
      chk("rr_hold", 64'(b0.y_valid), 64'b0100);
      put(1'b0, 2'd0, 8'h00);
      cyc();
      rr_mode = 1'b0;
`endif
      b1.s = 3'd6;
      b1.i_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         #4;
         chk("n5_ready", 64'(b1.i_ready), 64'd1);
         chk("n5_valid", 64'(b1.y_valid), 64'd0);
         chk("n5_drop", 64'(b1.drop_cnt), 64'(i > 255 ? 255 : i));
         @(posedge clk);
         #1;
      end
      b1.i_valid = 1'b0;
      chk("n5_sat", 64'(b1.drop_cnt), 64'd255);
      chk("n4_drop", 64'(b0.drop_cnt), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errs);
      $finish;
   end
endmodule
